// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between NUM_REQ cache
// controllers. The grant is locked for the whole transfer, and a sticky
// timeout flag reports transfers stalled on the memory side.
module cache_mem_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0]               req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_adr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
  output logic [DATA_WIDTH-1:0]            req_rdata_o,
  output logic                             mem_valid_o,
  input  logic                             mem_ready_i,
  output logic                             mem_we_o,
  output logic [ADDR_WIDTH-1:0]            mem_adr_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
  output logic [NUM_REQ-1:0]               grant_o,
  output logic                             timeout_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t              state, state_n;
  logic [NUM_REQ-1:0]  grant_q, grant_n;
  logic [IW-1:0]       gnt_idx, gnt_idx_n;
  logic [IW-1:0]       rr_ptr, rr_ptr_n;
  logic [IW-1:0]       pick_idx, cand;
  logic                pick_found;
  int unsigned         sum;
  logic [CW-1:0]       tcnt, tcnt_n;
  logic                timeout_q, timeout_n;
  logic                busy;

  logic [ADDR_WIDTH-1:0] adr_arr   [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign adr_arr[g]   = req_adr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: first valid requester after rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = 0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      sum = 32'(rr_ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IW'(sum);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state logic: grant on idle, release on completion or abort, timeout count.
  always_comb begin
    state_n   = state;
    grant_n   = grant_q;
    gnt_idx_n = gnt_idx;
    rr_ptr_n  = rr_ptr;
    tcnt_n    = tcnt;
    timeout_n = timeout_q;
    unique case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_n           = ST_BUSY;
          grant_n           = '0;
          grant_n[pick_idx] = 1'b1;
          gnt_idx_n         = pick_idx;
          rr_ptr_n          = pick_idx;
          tcnt_n            = '0;
        end
      end
      ST_BUSY: begin
        if (!req_valid_i[gnt_idx] || mem_ready_i) begin
          state_n = ST_IDLE;
          grant_n = '0;
        end else begin
          if (tcnt != TMAX) tcnt_n = tcnt + 1'b1;
          if ((TIMEOUT_CYCLES != 0) && (tcnt_n == TMAX)) timeout_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and arbitration registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      grant_q   <= '0;
      gnt_idx   <= '0;
      rr_ptr    <= IW'(NUM_REQ - 1);
      tcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      grant_q   <= grant_n;
      gnt_idx   <= gnt_idx_n;
      rr_ptr    <= rr_ptr_n;
      tcnt      <= tcnt_n;
      timeout_q <= timeout_n;
    end
  end

  // Forward the granted requester to memory; rst_i gates the path so a reset
  // mid-transfer drops the request in the same cycle rather than one later.
  always_comb begin
    busy        = (state == ST_BUSY) && !rst_i;
    mem_valid_o = busy && req_valid_i[gnt_idx];
    mem_we_o    = busy && req_we_i[gnt_idx];
    mem_adr_o   = busy ? adr_arr[gnt_idx] : '0;
    mem_wdata_o = busy ? wdata_arr[gnt_idx] : '0;
    req_ready_o = '0;
    if (busy) req_ready_o[gnt_idx] = mem_ready_i && req_valid_i[gnt_idx];
  end

  assign req_rdata_o = mem_rdata_i;
  assign grant_o     = grant_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized batches,
// checked by a scoreboard of expected transfers popped by a negedge monitor.
module tb_cache_mem_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;
  localparam int MAXT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_we, grant;
  logic [N*AW-1:0] req_adr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   req_rdata, mem_wdata, mem_rdata;
  logic            mem_valid, mem_ready, mem_we, timeout;
  logic [AW-1:0]   mem_adr;

  cache_mem_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_wdata_i(req_wdata), .req_rdata_o(req_rdata),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_we_o(mem_we),
    .mem_adr_o(mem_adr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .grant_o(grant), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   idx;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        tx [N*MAXT];
  int unsigned cnt [N];
  int unsigned model_last;
  int          checks = 0;
  int          failures = 0;
  logic [N-1:0] rdy_seen = '0;
  bit          prev_done = 1'b0;
  bit          auto_mem = 1'b0;
  int unsigned lat_lo = 0, lat_hi = 3;
  int          lat_left = -1;

  function automatic logic [DW-1:0] mem_fn(logic [AW-1:0] a);
    return {a ^ 16'h5A3C, ~a};
  endfunction

  function automatic txn_t mk(int unsigned r, logic we, logic [AW-1:0] a,
                              logic [DW-1:0] d, logic [DW-1:0] rd);
    txn_t t;
    t.idx = r; t.we = we; t.adr = a; t.wdata = d; t.rdata = rd;
    return t;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int unsigned r, logic v, txn_t t);
    req_valid[r]            = v;
    req_we[r]               = t.we;
    req_adr[r*AW +: AW]     = t.adr;
    req_wdata[r*DW +: DW]   = t.wdata;
  endtask

  // Monitor: pops the scoreboard on each completed transfer and checks invariants.
  always @(negedge clk) begin
    txn_t t;
    logic [N-1:0] oh;
    rdy_seen = req_ready;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      check("grant_onehot", 64'($countones(grant) <= 1), 64'd1);
      if (prev_done) check("post_done_idle", {grant, mem_valid}, '0);
      prev_done = 1'b0;
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", {grant, mem_adr}, '0);
        end else begin
          t = exp_q.pop_front();
          oh = '0;
          oh[t.idx] = 1'b1;
          check("xfer_grant", grant, oh);
          check("xfer_ready", req_ready, oh);
          check("xfer_we", mem_we, t.we);
          check("xfer_adr", mem_adr, t.adr);
          check("xfer_wdata", mem_wdata, t.wdata);
          check("xfer_rdata", req_rdata, t.rdata);
          prev_done = 1'b1;
        end
      end else begin
        check("no_spurious_ready", req_ready, '0);
      end
    end
  end

  // Memory responder: acknowledges after a random number of busy cycles.
  always @(posedge clk) begin
    #2;
    if (auto_mem) begin
      if (mem_valid) begin
        if (lat_left < 0) lat_left = int'($urandom_range(lat_hi, lat_lo));
        if (lat_left == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem_fn(mem_adr);
          lat_left  = -1;
        end else begin
          mem_ready = 1'b0;
          lat_left--;
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        lat_left  = -1;
      end
    end
  end

  // Every requester with work left is pending whenever the arbiter is idle,
  // so service order is plain round-robin over non-empty requesters.
  task automatic run_batch();
    int unsigned left [N];
    int unsigned pos [N];
    int unsigned last, total, c, budget;
    bit found;
    total = 0;
    for (int unsigned r = 0; r < N; r++) begin
      left[r] = cnt[r];
      total += cnt[r];
    end
    last = model_last;
    for (int unsigned k = 0; k < total; k++) begin
      found = 1'b0;
      for (int unsigned s = 1; s <= N; s++) begin
        c = (last + s) % N;
        if (!found && left[c] > 0) begin
          exp_q.push_back(tx[c*MAXT + (cnt[c] - left[c])]);
          left[c]--;
          last  = c;
          found = 1'b1;
        end
      end
    end
    model_last = last;
    auto_mem = 1'b1;
    cyc();
    for (int unsigned r = 0; r < N; r++) begin
      pos[r] = 0;
      if (cnt[r] > 0) drive(r, 1'b1, tx[r*MAXT]);
      else req_valid[r] = 1'b0;
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      cyc();
      budget++;
      for (int unsigned r = 0; r < N; r++) begin
        if (rdy_seen[r]) begin
          pos[r]++;
          if (pos[r] < cnt[r]) drive(r, 1'b1, tx[r*MAXT + pos[r]]);
          else req_valid[r] = 1'b0;
        end
      end
    end
    if (exp_q.size() != 0) begin
      check("batch_budget", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    cyc();
    req_valid = '0;
    auto_mem  = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    txn_t t;
    rst = 1'b1;
    req_valid = 2'b11; req_we = 2'b11; req_adr = '1; req_wdata = '1;
    mem_ready = 1'b0; mem_rdata = '0;
    model_last = N - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, '0);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_adr", mem_adr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_req_ready", req_ready, '0);
    check("rst_timeout", timeout, 1'b0);
    cyc();
    rst = 1'b0; req_valid = '0; req_we = '0; req_adr = '0; req_wdata = '0;

    // Single read from requester 0, acked 3 cycles after mem_valid.
    cyc();
    t = mk(0, 1'b0, 16'h0040, 32'h0, 32'hDEADBEEF);
    drive(0, 1'b1, t);
    @(negedge clk);
    check("single_idle_valid", mem_valid, 1'b0);
    cyc();
    @(negedge clk);
    check("single_valid", mem_valid, 1'b1);
    check("single_grant", grant, 2'b01);
    check("single_adr", mem_adr, 16'h0040);
    check("single_we", mem_we, 1'b0);
    cyc(); cyc(); cyc();
    exp_q.push_back(t);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    cyc();
    mem_ready = 1'b0; req_valid = '0;
    @(negedge clk);
    check("single_grant_clear", grant, '0);
    model_last = 0;

    // Write forwarded from requester 1 while requester 0 is idle.
    for (int unsigned r = 0; r < N; r++) cnt[r] = 0;
    cnt[1] = 1;
    tx[1*MAXT] = mk(1, 1'b1, 16'h1234, 32'hA5A5A5A5, mem_fn(16'h1234));
    run_batch();

    // Requester 0 aborts; requester 1 raises valid in the same cycle.
    cyc();
    drive(0, 1'b1, mk(0, 1'b0, 16'h0100, 32'h0, 32'h0));
    cyc();
    @(negedge clk);
    check("abort_grant0", grant, 2'b01);
    cyc();
    t = mk(1, 1'b0, 16'h0200, 32'h11112222, 32'h0BADF00D);
    req_valid[0] = 1'b0;
    drive(1, 1'b1, t);
    @(negedge clk);
    check("abort_mem_valid", mem_valid, 1'b0);
    cyc();
    @(negedge clk);
    check("abort_idle_grant", grant, '0);
    cyc();
    @(negedge clk);
    check("abort_next_grant", grant, 2'b10);
    check("abort_next_valid", mem_valid, 1'b1);
    exp_q.push_back(t);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    cyc();
    mem_ready = 1'b0; req_valid = '0;
    model_last = 1;

    // mem_ready while idle must not produce req_ready.
    cyc();
    mem_ready = 1'b1;
    @(negedge clk);
    check("idle_ready_ignored", req_ready, '0);
    cyc();
    @(negedge clk);
    check("idle_ready_grant", grant, '0);
    cyc();
    mem_ready = 1'b0;

    // Timeout: memory stalls; flag rises after TO busy cycles and is sticky.
    cyc();
    t = mk(0, 1'b1, 16'h0300, 32'hCAFE0001, 32'h55AA55AA);
    drive(0, 1'b1, t);
    for (int unsigned k = 1; k <= 12; k++) begin
      cyc();
      @(negedge clk);
      check("timeout_flag", timeout, (k > TO) ? 1'b1 : 1'b0);
      check("timeout_grant_held", grant, 2'b01);
    end
    exp_q.push_back(t);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
    cyc();
    mem_ready = 1'b0; req_valid = '0;
    @(negedge clk);
    check("timeout_sticky", timeout, 1'b1);
    cyc();
    @(negedge clk);
    check("timeout_sticky2", timeout, 1'b1);
    model_last = 0;

    // Reset while requester 1 holds the grant.
    cyc();
    drive(1, 1'b1, mk(1, 1'b0, 16'h0400, 32'h0, 32'h0));
    cyc();
    @(negedge clk);
    check("prerst_grant", grant, 2'b10);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("inrst_mem_valid", mem_valid, 1'b0);
    check("inrst_req_ready", req_ready, '0);
    cyc();
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
    check("postrst_grant", grant, '0);
    check("postrst_valid", mem_valid, 1'b0);
    check("postrst_timeout", timeout, 1'b0);
    model_last = N - 1;

    // Contention after reset: requester 0 first, then strict alternation.
    lat_lo = 1; lat_hi = 1;
    for (int unsigned r = 0; r < N; r++) begin
      cnt[r] = 2;
      for (int unsigned i = 0; i < 2; i++)
        tx[r*MAXT + i] = mk(r, 1'b0, AW'(16'h0500 + 16*r + i), 32'h0, mem_fn(AW'(16'h0500 + 16*r + i)));
    end
    run_batch();

    // Randomized batches with random counts, attributes and memory latency.
    lat_lo = 0; lat_hi = 3;
    for (int unsigned b = 0; b < 8; b++) begin
      for (int unsigned r = 0; r < N; r++) begin
        cnt[r] = $urandom_range(5, 0);
        for (int unsigned i = 0; i < cnt[r]; i++) begin
          t.idx   = r;
          t.we    = 1'($urandom_range(1, 0));
          t.adr   = AW'($urandom);
          t.wdata = $urandom;
          t.rdata = mem_fn(t.adr);
          tx[r*MAXT + i] = t;
        end
      end
      run_batch();
    end

    cyc();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
